// File: rtl/riscv_pkg.sv
// riscv_pkg: encodings shared by the core pipeline stages (funct3, writeback select, MEM FSM).
// Revision: 1.0
`default_nettype none

package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // Access size comes from funct3[1:0]; byte accesses can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic result;
    result = 1'b0;
    case (size)
      SZ_H:    result = offset[0];
      SZ_W:    result = (offset != 2'b00);
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a load word and sign/zero extends it.
// Revision: 1.0
`default_nettype none

module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (offset)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    // offset[0] is ignored for halves so unchecked misaligned halves still pick a lane.
    w_half = offset[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (funct3)
      F3_B:    data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   data = {24'd0, w_byte};
      F3_H:    data = {{16{w_half[15]}}, w_half};
      F3_HU:   data = {16'd0, w_half};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// mem_access: MEM stage issuing data-memory requests and producing the MEM/WB pipeline register.
// Revision: 1.0
`default_nettype none

module mem_access
  import riscv_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        mem_read_MEM,
  input  logic        mem_write_MEM,
  input  logic [2:0]  funct3_MEM,
  input  logic [1:0]  result_set_MEM,
  input  logic        reg_write_MEM,
  input  logic [4:0]  rd_MEM,
  input  logic [31:0] alu_result_MEM,
  input  logic [31:0] write_data_MEM,
  input  logic [31:0] pcPlus4_MEM,

  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,

  output logic        stall_MEM,

  output logic [1:0]  result_set_WB,
  output logic        reg_write_WB,
  output logic [4:0]  rd_WB,
  output logic [31:0] alu_result_WB,
  output logic [31:0] mem_data_WB,
  output logic [31:0] pcPlus4_WB,
  output logic        misaligned_WB
);

  mem_state_t  r_state;
  mem_state_t  w_next_state;
  logic [1:0]  r_offset;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_req;
  logic        w_complete;
  logic        w_load_done;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load_data;

  assign w_mem_op     = mem_read_MEM | mem_write_MEM;
  assign w_misaligned = (ALIGN_CHECK != 1'b0) && w_mem_op &&
                        is_misaligned(funct3_MEM[1:0], alu_result_MEM[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_req        = 1'b0;
    w_complete   = 1'b0;
    w_load_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_mem_op || w_misaligned) begin
          w_complete = 1'b1;
        end else begin
          w_req = 1'b1;
          if (!dmem_req_ready) begin
            w_next_state = REQ;
          end else if (mem_write_MEM) begin
            w_complete = 1'b1;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      REQ: begin
        w_req = 1'b1;
        if (dmem_req_ready) begin
          if (mem_write_MEM) begin
            w_complete   = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_rsp_valid) begin
          w_complete   = 1'b1;
          w_load_done  = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The offset is captured when the request leaves IDLE and reused for the load extract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset <= 2'b00;
    end else if (r_state == IDLE) begin
      r_offset <= alu_result_MEM[1:0];
    end
  end

  always_comb begin
    w_wdata = write_data_MEM;
    w_wstrb = 4'b1111;
    case (funct3_MEM[1:0])
      SZ_B: begin
        w_wdata = {4{write_data_MEM[7:0]}};
        w_wstrb = 4'b0001 << alu_result_MEM[1:0];
      end
      SZ_H: begin
        w_wdata = {2{write_data_MEM[15:0]}};
        w_wstrb = alu_result_MEM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = write_data_MEM;
        w_wstrb = 4'b1111;
      end
    endcase
  end

  // Reset forces every request-side output low even while the upstream fields are still held.
  assign dmem_req_valid = w_req & ~rst;
  assign dmem_we        = dmem_req_valid & mem_write_MEM;
  assign dmem_addr      = dmem_req_valid ? {alu_result_MEM[31:2], 2'b00} : 32'd0;
  assign dmem_wdata     = dmem_we ? w_wdata : 32'd0;
  assign dmem_wstrb     = dmem_we ? w_wstrb : 4'b0000;
  assign stall_MEM      = ~w_complete & ~rst;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (r_offset),
    .funct3 (funct3_MEM),
    .data   (w_load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_set_WB <= 2'b00;
      reg_write_WB  <= 1'b0;
      rd_WB         <= 5'd0;
      alu_result_WB <= 32'd0;
      mem_data_WB   <= 32'd0;
      pcPlus4_WB    <= 32'd0;
      misaligned_WB <= 1'b0;
    end else if (w_complete) begin
      result_set_WB <= result_set_MEM;
      reg_write_WB  <= reg_write_MEM & ~w_misaligned;
      rd_WB         <= rd_MEM;
      alu_result_WB <= alu_result_MEM;
      mem_data_WB   <= w_load_done ? w_load_data : 32'd0;
      pcPlus4_WB    <= pcPlus4_MEM;
      misaligned_WB <= w_misaligned;
    end else begin
      result_set_WB <= 2'b00;
      reg_write_WB  <= 1'b0;
      rd_WB         <= 5'd0;
      alu_result_WB <= 32'd0;
      mem_data_WB   <= 32'd0;
      pcPlus4_WB    <= 32'd0;
      misaligned_WB <= 1'b0;
    end
  end

endmodule

`default_nettype wire
